// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, exception codes
// and controller states.
package pipeline_ctrl_pkg;

   localparam logic STOP     = 1'b1;
   localparam logic NOT_STOP = 1'b0;

   // Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
   localparam logic [5:0] STALL_NONE = {6{NOT_STOP}};
   localparam logic [5:0] STALL_IF   = {{4{NOT_STOP}}, {2{STOP}}};
   localparam logic [5:0] STALL_ID   = {{3{NOT_STOP}}, {3{STOP}}};
   localparam logic [5:0] STALL_EX   = {{2{NOT_STOP}}, {4{STOP}}};
   localparam logic [5:0] STALL_MEM  = {NOT_STOP, {5{STOP}}};

   localparam logic [31:0] EXC_NONE = 32'h0000_0000;
   localparam logic [31:0] EXC_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
   localparam logic [31:0] EXC_ADES = 32'h0000_0005;
   localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_BP   = 32'h0000_0009;
   localparam logic [31:0] EXC_RI   = 32'h0000_000A;
   localparam logic [31:0] EXC_OV   = 32'h0000_000C;
   localparam logic [31:0] EXC_TR   = 32'h0000_000D;
   localparam logic [31:0] EXC_ERET = 32'h0000_000E;

   typedef enum logic {
      CTRL_RUN    = 1'b0,
      CTRL_REFILL = 1'b1
   } ctrl_state_e;

   // The deepest requesting stage wins: stalling it freezes everything upstream.
   function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
      logic [5:0] v;
      v = STALL_NONE;
      if (req_mem)     v = STALL_MEM;
      else if (req_ex) v = STALL_EX;
      else if (req_id) v = STALL_ID;
      else if (req_if) v = STALL_IF;
      return v;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter
   import pipeline_ctrl_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst || clr)
         r_q <= '0;
      else if (inc && (r_q != MAX))
         r_q <= r_q + 1'b1;
   end

   assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: arbitrates stage stall requests against MEM-stage
// exceptions, with a post-flush refill window, stall watchdog and perf counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
   parameter int          REFILL_CYCLES = 2,
   parameter int          WDT_LIMIT     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] mem_exception_type,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   localparam logic [3:0]  REFILL_INIT = 4'(REFILL_CYCLES);
   localparam logic [15:0] WDT_MAX     = 16'(WDT_LIMIT);
   localparam logic [15:0] WDT_LAST    = 16'(WDT_LIMIT - 1);

   ctrl_state_e r_state;
   ctrl_state_e w_state_next;
   logic [3:0]  r_refill_cnt;
   logic [3:0]  w_refill_next;
   logic        r_stall_timeout;
   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_new_pc;
   logic        w_stalled;
   logic [15:0] w_wdt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= CTRL_RUN;
         r_refill_cnt <= 4'd0;
      end else begin
         r_state      <= w_state_next;
         r_refill_cnt <= w_refill_next;
      end
   end

   always_comb begin
      w_stall       = STALL_NONE;
      w_flush       = 1'b0;
      w_new_pc      = 32'h0;
      w_state_next  = r_state;
      w_refill_next = r_refill_cnt;
      if (!rst) begin
         // An exception in RUN squashes everything, so stall requests are moot.
         if ((r_state == CTRL_RUN) && (mem_exception_type != EXC_NONE)) begin
            w_flush       = 1'b1;
            w_new_pc      = (mem_exception_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
            w_state_next  = CTRL_REFILL;
            w_refill_next = REFILL_INIT;
         end else begin
            w_stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
            if (r_state == CTRL_REFILL) begin
               w_refill_next = r_refill_cnt - 4'd1;
               if (r_refill_cnt <= 4'd1)
                  w_state_next = CTRL_RUN;
            end
         end
      end
   end

   assign w_stalled = (w_stall != STALL_NONE);

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_timeout <= 1'b0;
      else if (w_stalled && (w_wdt_q >= WDT_LAST))
         r_stall_timeout <= 1'b1;
   end

   sat_counter #(.WIDTH(32)) u_stall_cycles (
      .clk (clk),
      .rst (rst),
      .inc (w_stalled),
      .clr (1'b0),
      .q   (stall_cycles)
   );

   sat_counter #(.WIDTH(16)) u_flush_count (
      .clk (clk),
      .rst (rst),
      .inc (w_flush),
      .clr (1'b0),
      .q   (flush_count)
   );

   sat_counter #(.WIDTH(16), .MAX(WDT_MAX)) u_watchdog (
      .clk (clk),
      .rst (rst),
      .inc (w_stalled),
      .clr (!w_stalled || w_flush),
      .q   (w_wdt_q)
   );

   assign stall         = w_stall;
   assign flush         = w_flush;
   assign new_pc        = w_new_pc;
   assign stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected stall/flush/new_pc per cycle are
// queued when inputs are driven and popped when outputs are sampled.
module tb_pipeline_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
   localparam logic [31:0] EPC = 32'h8000_1234;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] mem_exception_type;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   pipeline_ctrl #(
      .EXC_VECTOR    (VEC),
      .REFILL_CYCLES (2),
      .WDT_LIMIT     (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .stallreq_if        (stallreq_if),
      .stallreq_id        (stallreq_id),
      .stallreq_ex        (stallreq_ex),
      .stallreq_mem       (stallreq_mem),
      .mem_exception_type (mem_exception_type),
      .cp0_epc            (cp0_epc),
      .stall              (stall),
      .flush              (flush),
      .new_pc             (new_pc),
      .stall_timeout      (stall_timeout),
      .stall_cycles       (stall_cycles),
      .flush_count        (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // req = {mem, ex, id, if}; inputs change 1 time unit after a rising edge.
   task automatic drive(input logic r, input logic [3:0] req, input logic [31:0] exc,
                        input logic [31:0] epc, input logic [5:0] es, input logic ef,
                        input logic [31:0] ep);
      exp_t e;
      rst = r;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
      mem_exception_type = exc;
      cp0_epc = epc;
      e.stall = es;
      e.flush = ef;
      e.pc    = ep;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
      mem_exception_type = 32'h0;
      cp0_epc = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (k < 2) drive(1'b1, 4'b1000, 32'h8, EPC, 6'b000000, 1'b0, 32'h0);
         else       drive(1'b0, 4'b1000, 32'h0, EPC, 6'b011111, 1'b0, 32'h0);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL reset[%0d] outputs: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({stall_timeout, stall_cycles, flush_count} !== {1'b0, 32'(k / 2), 16'h0}) begin
            n_mis++;
            $display("FAIL reset[%0d] counters: got to=%b cyc=%0d fc=%0d, want to=0 cyc=%0d fc=0",
                     k, stall_timeout, stall_cycles, flush_count, k / 2);
         end
      end
   endtask

   task automatic test_priority();
      exp_t        e;
      logic [3:0]  req;
      logic [5:0]  es;
      logic [31:0] cyc;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         case (k)
            0:       begin req = 4'b0110; es = 6'b001111; cyc = 1; end
            1:       begin req = 4'b0010; es = 6'b000111; cyc = 2; end
            2:       begin req = 4'b0001; es = 6'b000011; cyc = 3; end
            3:       begin req = 4'b1001; es = 6'b011111; cyc = 4; end
            default: begin req = 4'b0000; es = 6'b000000; cyc = 4; end
         endcase
         drive(1'b0, req, 32'h0, 32'h0, es, 1'b0, 32'h0);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL priority[%0d] req=%b: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, req, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (stall_cycles !== cyc) begin
            n_mis++;
            $display("FAIL priority[%0d] stall_cycles: got %0d want %0d", k, stall_cycles, cyc);
         end
      end
   endtask

   task automatic test_syscall_refill();
      exp_t        e;
      logic [3:0]  req;
      logic [31:0] exc;
      logic [5:0]  es;
      logic        ef;
      logic [15:0] fc;
      logic [31:0] cyc;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         case (k)
            0:       begin req = 4'b1000; exc = 32'h8; es = 6'b000000; ef = 1'b1; fc = 1; cyc = 0; end
            1:       begin req = 4'b1000; exc = 32'h8; es = 6'b011111; ef = 1'b0; fc = 1; cyc = 1; end
            2:       begin req = 4'b0000; exc = 32'h8; es = 6'b000000; ef = 1'b0; fc = 1; cyc = 1; end
            3:       begin req = 4'b0000; exc = 32'h8; es = 6'b000000; ef = 1'b1; fc = 2; cyc = 1; end
            4:       begin req = 4'b0000; exc = 32'h0; es = 6'b000000; ef = 1'b0; fc = 2; cyc = 1; end
            5:       begin req = 4'b0000; exc = 32'h0; es = 6'b000000; ef = 1'b0; fc = 2; cyc = 1; end
            default: begin req = 4'b0100; exc = 32'h4; es = 6'b000000; ef = 1'b1; fc = 3; cyc = 1; end
         endcase
         drive(1'b0, req, exc, EPC, es, ef, ef ? VEC : 32'h0);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL syscall[%0d] exc=%h: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, exc, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({flush_count, stall_cycles} !== {fc, cyc}) begin
            n_mis++;
            $display("FAIL syscall[%0d] counters: got fc=%0d cyc=%0d, want fc=%0d cyc=%0d",
                     k, flush_count, stall_cycles, fc, cyc);
         end
      end
   endtask

   task automatic test_eret();
      exp_t        e;
      logic [3:0]  req;
      logic [31:0] exc;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin req = 4'b0010; exc = 32'hE; drive(1'b0, req, exc, EPC, 6'b000000, 1'b1, EPC); end
            1: begin req = 4'b0010; exc = 32'h0; drive(1'b0, req, exc, EPC, 6'b000111, 1'b0, 32'h0); end
            2: begin req = 4'b0000; exc = 32'hE; drive(1'b0, req, exc, EPC, 6'b000000, 1'b0, 32'h0); end
            default: begin req = 4'b0000; exc = 32'hE; drive(1'b0, req, exc, EPC, 6'b000000, 1'b1, EPC); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL eret[%0d] exc=%h: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, exc, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_in_refill();
      exp_t e;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         if (k == 1) drive(1'b1, 4'b0000, 32'h9, EPC, 6'b000000, 1'b0, 32'h0);
         else        drive(1'b0, 4'b0000, 32'h9, EPC, 6'b000000, 1'b1, VEC);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL rst_refill[%0d]: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (flush_count !== 16'd1) begin
         n_mis++;
         $display("FAIL rst_refill flush_count: got %0d want 1", flush_count);
      end
   endtask

   task automatic test_watchdog();
      exp_t e;
      logic on;
      logic to_exp;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         on     = (k < 3) || ((k >= 4) && (k < 9));
         to_exp = (k >= 7);
         drive(1'b0, on ? 4'b0100 : 4'b0000, 32'h0, 32'h0, on ? 6'b001111 : 6'b000000, 1'b0, 32'h0);
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
            n_mis++;
            $display("FAIL watchdog[%0d] outputs: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                     k, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (stall_timeout !== to_exp) begin
            n_mis++;
            $display("FAIL watchdog[%0d] stall_timeout: got %b want %b", k, stall_timeout, to_exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
      mem_exception_type = 32'h0;
      cp0_epc = 32'h0;
      @(posedge clk); #1;
      test_reset();
      test_priority();
      test_syscall_refill();
      test_eret();
      test_reset_in_refill();
      test_watchdog();
      n_cmp++;
      if (sb.size() != 0) begin
         n_mis++;
         $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline controller that produces the per-stage stall vector, the pipeline flush pulse and the exception redirect PC.
- These signals are consumed by every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) and by the PC unit.
- Arbitrates stall requests from the IF (AXI fetch), ID (load-use), EX (multi-cycle div/madd) and MEM (AXI data) stages against exceptions committed in MEM.
- Adds a post-flush refill window, a stall watchdog and stall/flush performance counters.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- REFILL_CYCLES, 2, cycles after a flush during which exceptions are ignored; range 1..15.
- WDT_LIMIT, 1024, consecutive stalled cycles before stall_timeout is set; range 2..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stallreq_if  in  1  IF stage (instruction bus busy) requests stall
- stallreq_id  in  1  ID stage (load-use hazard) requests stall
- stallreq_ex  in  1  EX stage (multi-cycle op) requests stall
- stallreq_mem  in  1  MEM stage (data bus busy) requests stall
- mem_exception_type  in  32  final exception code from MEM; 0 = none
- cp0_epc  in  32  current EPC from CP0 (already bypassed)
- stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP
- flush  out  1  squash all pipeline registers this cycle
- new_pc  out  32  redirect PC, valid while flush=1
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  32  count of cycles with stall!=0
- flush_count  out  16  count of flush pulses

Behaviour:
- Combinational path: stall, flush and new_pc depend combinationally on the current inputs and on the registered state, so stages see them in the same cycle.
- Reset, synchronous (rst=1 at posedge):
  - state=RUN, refill counter=0, watchdog counter=0.
  - stall_timeout=0, stall_cycles=0, flush_count=0.
  - While rst=1: stall=0, flush=0, new_pc=0.
- Exception taken: state RUN and mem_exception_type!=0.
  - flush=1 and stall=6'b000000 for that single cycle; all stall requests are ignored.
  - new_pc = cp0_epc if mem_exception_type==32'h0000000E (eret), else EXC_VECTOR. Codes 1, 4, 5, 8, 9, A, C, D all go to EXC_VECTOR.
  - Next state is REFILL with counter=REFILL_CYCLES; flush_count increments with saturation at 16'hFFFF.
- Otherwise flush=0 and new_pc=0.
- Stall priority (highest request wins):
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- REFILL state:
  - mem_exception_type is ignored, since it belongs to squashed bubbles; flush=0.
  - Stall requests are honoured as in RUN.
  - The counter decrements every cycle; at counter==1 the next state is RUN.
  - Decrementing does not depend on stall.
- stall_cycles: increments, saturating, on every cycle with stall!=0, including cycles in REFILL.
- Watchdog:
  - The counter increments each cycle stall!=0 and clears to 0 on any cycle with stall==0 or flush==1.
  - When the counter reaches WDT_LIMIT, stall_timeout is set to 1 and stays set until rst.
  - The counter saturates at WDT_LIMIT.
- Simultaneous events: exception plus any stall request in RUN resolves to flush only. Reset during REFILL returns to RUN next cycle with all counters cleared.
- Latency: flush/stall are zero-cycle. Counters and stall_timeout update on the edge after the qualifying cycle.

Decomposition:
- Shared header additions:
  - stall encodings STALL_NONE/IF/ID/EX/MEM.
  - exception codes EXC_INT/ADEL/ADES/SYS/BP/RI/OV/TR/ERET.
  - state encodings CTRL_RUN/CTRL_REFILL.
  - STOP/NOT_STOP reuse the existing definitions.
- Sub-module sat_counter (parameter WIDTH; ports inc, clr, q) is used for stall_cycles, flush_count and the watchdog counter.

Test Plan:
- Reset: assert rst 2 cycles with stallreq_mem=1 and exception_type=8 → stall=0, flush=0, new_pc=0 and all counters 0; after release, stall=6'b011111.
- Priority: stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111. Drop ex → 6'b000111. Drop id, raise if → 6'b000011. stall_cycles=3 after these 3 cycles.
- Syscall: exception_type=32'h8 in RUN with stallreq_mem=1 → one cycle flush=1, new_pc=32'hBFC00380, stall=0. flush_count=1.
- Refill masking: after the syscall, hold exception_type=32'h8 for the next 2 cycles → flush stays 0. In the 3rd cycle the exception is taken again and flush_count=2.
- Eret: cp0_epc=32'h80001234, exception_type=32'hE → flush=1, new_pc=32'h80001234.
- Watchdog: WDT_LIMIT=4, hold stallreq_ex for 3 cycles then release → stall_timeout=0. Hold for 5 cycles → stall_timeout=1, and it stays 1 after the stall ends.
